pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the write-enable and flush controls of the IF/ID and ID/EX pipeline registers, the PC write enable, and the EX-stage hold used by the multi-cycle mul/div unit.
- Runs a post-reset flush sequence, detects load-use hazards, squashes wrong-path instructions on taken branches, and holds the front of the pipe while a mul/div occupies EX.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 24 ++
 rtl/pipeline_hazard_ctrl_if.sv | 31 +++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 24 ++
 rtl/pipeline_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: sequencer state encoding, register-file address
// constants and the NOP word loaded into squashed pipeline registers.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    // sll $0,$0,0 -- the canonical all-zero NOP used by IF/ID and ID/EX bubbles
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_MD_BUSY = 2'd2
    } hazard_state_e;

    // A source matches a producer only when the producer writes a real register.
    function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] dst);
        return (dst != ZERO_REG) && (dst == src);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of ID/EX hazard inputs and pipeline-register control outputs
// exchanged between the datapath and the hazard sequencer.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic                  ex_branch_taken;
    logic                  ex_md_op;

    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  ex_stall;
    logic                  md_done;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken, ex_md_op,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_stall, md_done
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken, ex_md_op,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_stall, md_done
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// register a load in EX has not yet returned.
module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    output logic                  load_use
);

    logic rs_hit;
    logic rt_hit;

    always_comb begin
        rs_hit   = reg_hit(id_rs, ex_rt);
        // rt only matters when the ID instruction actually sources it
        rt_hit   = id_uses_rt && reg_hit(id_rt, ex_rt);
        load_use = ex_mem_read && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: post-reset flush, load-use
// bubbles, taken-branch squash and mul/div EX occupancy.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES = 2,
    parameter int MD_LATENCY  = 4,
    parameter int CNT_W       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MD_LOAD   = (MD_LATENCY >= 2) ? CNT_W'(MD_LATENCY - 2) : '0;
    localparam logic             MD_STALLS = (MD_LATENCY > 1);

    hazard_state_e    state_q;
    hazard_state_e    state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic load_use;
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_stall;
    logic md_done;

    pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
        .ex_mem_read (bus.ex_mem_read),
        .ex_rt       (bus.ex_rt),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rt  (bus.id_uses_rt),
        .load_use    (load_use)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= INIT_LOAD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_stall    = 1'b0;
        md_done     = 1'b0;

        case (state_q)
            ST_RUN: begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                if (bus.ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (bus.ex_md_op && MD_STALLS) begin
                    // front of pipe frozen, so a pending load-use resolves itself
                    ex_stall    = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    state_d     = ST_MD_BUSY;
                    cnt_d       = MD_LOAD;
                end else begin
                    md_done = bus.ex_md_op;
                    if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
            end

            ST_MD_BUSY: begin
                if (cnt_q != '0) begin
                    ex_stall = 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                end else begin
                    md_done     = 1'b1;
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    state_d     = ST_RUN;
                end
            end

            default: begin
                // ST_INIT, and any illegal encoding falls back to INIT behaviour
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                    cnt_d   = cnt_q - 1'b1;
                end
            end
        endcase

        if (!rst_n) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ex_stall    = 1'b0;
            md_done     = 1'b0;
        end
    end

    assign bus.pc_write    = pc_write;
    assign bus.if_id_write = if_id_write;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.ex_stall    = ex_stall;
    assign bus.md_done     = md_done;

    // A taken branch cannot resolve while a mul/div still owns EX.
    a_no_branch_in_md_busy: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q == ST_MD_BUSY) |-> !bus.ex_branch_taken
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed vector table, reset-during-mul/div sequence and randomized traffic
// checked against an abstract cycle model of the hazard sequencer.
module tb_pipeline_hazard_ctrl;

    localparam int INIT_CYCLES = 2;
    localparam int MD_LATENCY  = 4;
    localparam int CNT_W       = 4;

    // expected output vector order: {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_stall, md_done}
    localparam logic [5:0] O_INIT = 6'b001100;
    localparam logic [5:0] O_RUN  = 6'b110000;
    localparam logic [5:0] O_LU   = 6'b000100;
    localparam logic [5:0] O_BR   = 6'b111100;
    localparam logic [5:0] O_STL  = 6'b000010;
    localparam logic [5:0] O_DONE = 6'b110001;

    typedef struct {
        logic       rst_n;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rt;
        logic       ex_mem_read;
        logic [4:0] ex_rt;
        logic       ex_branch_taken;
        logic       ex_md_op;
        logic [5:0] exp;
        string      name;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // abstract model state: flush cycles still owed, EX cycles left for the mul/div
    int init_left;
    int busy_left;
    int n_init;
    int n_busy;

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl #(
        .INIT_CYCLES (INIT_CYCLES),
        .MD_LATENCY  (MD_LATENCY),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] model_eval();
        logic [5:0] e;
        logic       lu;
        n_init = init_left;
        n_busy = busy_left;
        lu = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
             ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
        if (!rst_n) begin
            e = O_INIT;
            n_init = INIT_CYCLES;
            n_busy = 0;
        end else if (init_left > 0) begin
            e = O_INIT;
            n_init = init_left - 1;
        end else if (busy_left > 1) begin
            e = O_STL;
            n_busy = busy_left - 1;
        end else if (busy_left == 1) begin
            e = O_DONE;
            n_busy = 0;
        end else if (bus.ex_branch_taken) begin
            e = O_BR;
        end else if (bus.ex_md_op && MD_LATENCY > 1) begin
            e = O_STL;
            n_busy = MD_LATENCY - 1;
        end else begin
            e = lu ? O_LU : O_RUN;
            e[0] = bus.ex_md_op;
        end
        return e;
    endfunction

    task automatic step(input vec_t v, input logic use_table);
        logic [5:0] exp;
        logic [5:0] act;
        logic [5:0] mexp;
        rst_n               = v.rst_n;
        bus.id_rs           = v.id_rs;
        bus.id_rt           = v.id_rt;
        bus.id_uses_rt      = v.id_uses_rt;
        bus.ex_mem_read     = v.ex_mem_read;
        bus.ex_rt           = v.ex_rt;
        bus.ex_branch_taken = v.ex_branch_taken;
        bus.ex_md_op        = v.ex_md_op;
        #2;
        mexp = model_eval();
        exp  = use_table ? v.exp : mexp;
        act  = {bus.pc_write, bus.if_id_write, bus.if_id_flush,
                bus.id_ex_flush, bus.ex_stall, bus.md_done};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: outputs %b, required %b", v.name, act, exp);
        end else begin
            $display("ok   %s: outputs %b", v.name, act);
        end
        @(posedge clk);
        init_left = n_init;
        busy_left = n_busy;
        @(negedge clk);
    endtask

    function automatic vec_t mk(logic rn, logic [4:0] rs, logic [4:0] rt, logic urt,
                                logic mr, logic [4:0] ert, logic br, logic md,
                                logic [5:0] exp, string nm);
        vec_t v;
        v.rst_n = rn; v.id_rs = rs; v.id_rt = rt; v.id_uses_rt = urt;
        v.ex_mem_read = mr; v.ex_rt = ert; v.ex_branch_taken = br; v.ex_md_op = md;
        v.exp = exp; v.name = nm;
        return v;
    endfunction

    vec_t vecs[17];
    vec_t rv;

    initial begin
        checks    = 0;
        errors    = 0;
        init_left = INIT_CYCLES;
        busy_left = 0;
        rst_n               = 1'b0;
        bus.id_rs           = '0;
        bus.id_rt           = '0;
        bus.id_uses_rt      = 1'b0;
        bus.ex_mem_read     = 1'b0;
        bus.ex_rt           = '0;
        bus.ex_branch_taken = 1'b0;
        bus.ex_md_op        = 1'b0;

        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, O_INIT, "reset");
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, O_INIT, "init_1");
        vecs[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, O_INIT, "init_2");
        vecs[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, O_RUN,  "run_first");
        vecs[4]  = mk(1, 5, 0, 0, 1, 5, 0, 0, O_LU,   "load_use_rs");
        vecs[5]  = mk(1, 5, 0, 0, 0, 5, 0, 0, O_RUN,  "after_bubble");
        vecs[6]  = mk(1, 0, 0, 0, 1, 0, 0, 0, O_RUN,  "load_r0");
        vecs[7]  = mk(1, 3, 7, 0, 1, 7, 0, 0, O_RUN,  "rt_unused");
        vecs[8]  = mk(1, 3, 7, 1, 1, 7, 0, 0, O_LU,   "rt_used");
        vecs[9]  = mk(1, 5, 0, 0, 1, 5, 1, 0, O_BR,   "branch_over_lu");
        vecs[10] = mk(1, 0, 0, 0, 0, 0, 0, 1, O_STL,  "md_stall_1");
        vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, O_STL,  "md_stall_2");
        vecs[12] = mk(1, 9, 0, 0, 1, 9, 0, 0, O_STL,  "md_stall_3");
        vecs[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, O_DONE, "md_done");
        vecs[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, O_RUN,  "md_after");
        vecs[15] = mk(1, 0, 0, 0, 0, 0, 1, 1, O_BR,   "branch_over_md");
        vecs[16] = mk(1, 0, 0, 0, 0, 0, 0, 0, O_RUN,  "no_md_busy");

        @(negedge clk);
        for (int i = 0; i < 17; i++) step(vecs[i], 1'b1);

        // reset pulse while mul/div still holds EX with one stall left
        step(mk(1, 0, 0, 0, 0, 0, 0, 1, O_STL,  "mdrst_start"), 1'b1);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, O_STL,  "mdrst_busy2"), 1'b1);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, O_INIT, "mdrst_reset"), 1'b1);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, O_INIT, "mdrst_init1"), 1'b1);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, O_INIT, "mdrst_init2"), 1'b1);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, O_RUN,  "mdrst_run"), 1'b1);

        for (int i = 0; i < 400; i++) begin
            rv = mk($urandom_range(49) != 0, 5'($urandom_range(7)), 5'($urandom_range(7)),
                    1'($urandom), ($urandom_range(2) == 0), 5'($urandom_range(7)),
                    ($urandom_range(5) == 0), ($urandom_range(7) == 0), 6'b0, "random");
            if (busy_left > 0) rv.ex_branch_taken = 1'b0;
            step(rv, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
